// File: rtl/pet2001_scandoubler.sv
// pet2001_scandoubler: captures one 7 MHz video line into a ping-pong line
// buffer and replays the previously captured line twice at the 14 MHz rate.
// Line length and horizontal sync width are measured from the incoming stream.
module pet2001_scandoubler #(
  parameter int ADDR_W = 9
) (
  input  logic clk,
  input  logic reset,
  input  logic ce_7mp,
  input  logic ce_7mn,
  input  logic pix_in,
  input  logic hsync_in,
  input  logic vsync_in,
  output logic pix_out,
  output logic hsync_out,
  output logic vsync_out
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] CNT_MAX = '1;
  localparam logic [ADDR_W-1:0] CNT_ONE = ADDR_W'(1);

  // Line buffer: both banks in one array, bank select is the address MSB.
  logic mem [0:2*DEPTH-1];

  // Input-side state
  logic              hs_dly_q,   hs_dly_d;
  logic              wbank_q,    wbank_d;
  logic [ADDR_W-1:0] icnt_q,     icnt_d;
  logic [ADDR_W-1:0] hcnt_q,     hcnt_d;
  logic [ADDR_W-1:0] hs_len_q,   hs_len_d;
  logic [ADDR_W-1:0] line_len_q, line_len_d;

  // Output-side state
  logic [ADDR_W-1:0] ocnt_q,     ocnt_d;
  logic              hsync_q,    hsync_d;
  logic              vsync_q,    vsync_d;
  logic              pix_gate_q, pix_gate_d;
  logic              rd_bit_q;

  // Decoded events
  logic              line_start;
  logic              hs_fall;
  logic              tick;
  logic              wr_en;
  logic [ADDR_W-1:0] len_eff;
  logic [ADDR_W-1:0] ocnt_eff;
  logic              rbank_eff;
  logic [ADDR_W:0]   waddr;
  logic [ADDR_W:0]   raddr;

  // Edge detection on the input sync and selection of the effective read
  // position; a line start overrides the replay position so that the same
  // tick already shows address 0 of the bank that was just completed.
  always_comb begin
    line_start = ce_7mp & hsync_in & ~hs_dly_q;
    hs_fall    = ce_7mp & ~hsync_in & hs_dly_q;
    tick       = ce_7mp | ce_7mn;
    wr_en      = ce_7mp & ~line_start & ~reset;
    len_eff    = line_start ? icnt_q : line_len_q;
    ocnt_eff   = line_start ? '0 : ocnt_q;
    rbank_eff  = line_start ? wbank_q : ~wbank_q;
    waddr      = {wbank_q, icnt_q};
    raddr      = {rbank_eff, ocnt_eff};
  end

  // Input side: capture counter, sync width measurement, bank swap at line start.
  always_comb begin
    hs_dly_d   = hs_dly_q;
    wbank_d    = wbank_q;
    icnt_d     = icnt_q;
    hcnt_d     = hcnt_q;
    hs_len_d   = hs_len_q;
    line_len_d = line_len_q;
    vsync_d    = vsync_q;

    if (ce_7mp) begin
      hs_dly_d = hsync_in;

      if (line_start) begin
        line_len_d = icnt_q;
        icnt_d     = '0;
        wbank_d    = ~wbank_q;
        vsync_d    = vsync_in;
        // The line-start sample is itself the first high cycle of the pulse.
        hcnt_d     = CNT_ONE;
      end else begin
        // Saturate so an over-long line keeps rewriting the last location.
        if (icnt_q != CNT_MAX) begin
          icnt_d = icnt_q + CNT_ONE;
        end
        if (hsync_in && (hcnt_q != CNT_MAX)) begin
          hcnt_d = hcnt_q + CNT_ONE;
        end
      end

      if (hs_fall) begin
        hs_len_d = hcnt_q;
      end
    end
  end

  // Output side: replay position, doubled-rate sync and pixel mask per tick.
  always_comb begin
    ocnt_d     = ocnt_q;
    hsync_d    = hsync_q;
    pix_gate_d = pix_gate_q;

    if (tick) begin
      hsync_d    = (ocnt_eff < hs_len_q);
      // An empty line (nothing measured yet) masks stale buffer contents.
      pix_gate_d = (len_eff != '0);
      if (len_eff == '0) begin
        ocnt_d = '0;
      end else if (ocnt_eff >= (len_eff - CNT_ONE)) begin
        ocnt_d = '0;
      end else begin
        ocnt_d = ocnt_eff + CNT_ONE;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      hs_dly_q   <= 1'b0;
      wbank_q    <= 1'b0;
      icnt_q     <= '0;
      hcnt_q     <= '0;
      hs_len_q   <= '0;
      line_len_q <= '0;
      ocnt_q     <= '0;
      hsync_q    <= 1'b0;
      vsync_q    <= 1'b0;
      pix_gate_q <= 1'b0;
    end else begin
      hs_dly_q   <= hs_dly_d;
      wbank_q    <= wbank_d;
      icnt_q     <= icnt_d;
      hcnt_q     <= hcnt_d;
      hs_len_q   <= hs_len_d;
      line_len_q <= line_len_d;
      ocnt_q     <= ocnt_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
      pix_gate_q <= pix_gate_d;
    end
  end

  // Line buffer write port and registered read port; the banks never collide.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[waddr] <= pix_in;
    end
    if (tick) begin
      rd_bit_q <= mem[raddr];
    end
  end

  assign pix_out   = rd_bit_q & pix_gate_q;
  assign hsync_out = hsync_q;
  assign vsync_out = vsync_q;

endmodule
